// File: rtl/byte_wb_regfile_pkg.sv
// Processor-wide constants and the write-back entry type shared by the
// byte-wide pipeline (result width, register address width, retire counter width).
package byte_wb_regfile_pkg;

    localparam int WB_DATA_W = 8;
    localparam int WB_ADDR_W = 3;
    localparam int RETIRE_W  = 16;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/byte_regfile_core.sv
// Register storage: one synchronous write port, two raw combinational read ports.
// Optional WB_ZERO_REG_EN makes writes to r0 ineffective so r0 stays at its reset value of 0.
module byte_regfile_core
    import byte_wb_regfile_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int NREGS  = 8,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_mem [NREGS];
    logic              w_we;

`ifdef WB_ZERO_REG_EN
    assign w_we = i_we && (i_waddr != '0);
`else
    assign w_we = i_we;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '{default: '0};
        end else if (w_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/byte_wb_regfile.sv
// Write-back stage: single-entry result register with valid/ready intake, commit to the
// register file, and forwarding of the pending result. Macro WB_ZERO_REG_EN hardwires r0 to 0.
module byte_wb_regfile
    import byte_wb_regfile_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int NREGS  = 8,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic                res_we,
    input  logic [ADDR_W-1:0]   res_rd,
    input  logic [DATA_W-1:0]   res_data,
    input  logic                wb_stall,
    input  logic [ADDR_W-1:0]   rs1_addr,
    output logic [DATA_W-1:0]   rs1_data,
    input  logic [ADDR_W-1:0]   rs2_addr,
    output logic [DATA_W-1:0]   rs2_data,
    output logic                wb_pending,
    output logic [RETIRE_W-1:0] retire_cnt
);

    wb_entry_t             r_wb;
    logic                  r_wb_valid;
    logic [RETIRE_W-1:0]   r_retire_cnt;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_fwd1;
    logic                  w_fwd2;
    logic [DATA_W-1:0]     w_raw1;
    logic [DATA_W-1:0]     w_raw2;

    assign res_ready = !r_wb_valid || !wb_stall;
    assign w_accept  = res_valid && res_ready;
    assign w_commit  = r_wb_valid && !wb_stall;

    // Accept has priority over clearing valid so accept+commit on one edge keeps full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid   <= 1'b0;
            r_wb         <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_wb_valid <= 1'b1;
                r_wb.we    <= res_we;
                r_wb.rd    <= res_rd;
                r_wb.data  <= res_data;
            end else if (w_commit) begin
                r_wb_valid <= 1'b0;
            end
            if (w_commit) begin
                r_retire_cnt <= r_retire_cnt + RETIRE_W'(1);
            end
        end
    end

    byte_regfile_core #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_commit && r_wb.we),
        .i_waddr  (r_wb.rd),
        .i_wdata  (r_wb.data),
        .i_raddr1 (rs1_addr),
        .o_rdata1 (w_raw1),
        .i_raddr2 (rs2_addr),
        .o_rdata2 (w_raw2)
    );

`ifdef WB_ZERO_REG_EN
    assign w_fwd1 = r_wb_valid && r_wb.we && (r_wb.rd == rs1_addr) && (rs1_addr != '0);
    assign w_fwd2 = r_wb_valid && r_wb.we && (r_wb.rd == rs2_addr) && (rs2_addr != '0);
`else
    assign w_fwd1 = r_wb_valid && r_wb.we && (r_wb.rd == rs1_addr);
    assign w_fwd2 = r_wb_valid && r_wb.we && (r_wb.rd == rs2_addr);
`endif

    assign rs1_data   = w_fwd1 ? r_wb.data : w_raw1;
    assign rs2_data   = w_fwd2 ? r_wb.data : w_raw2;
    assign wb_pending = r_wb_valid;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_byte_wb_regfile.sv
// Directed bench for byte_wb_regfile; inputs are driven and outputs sampled on the falling edge.
// Expected values are hand-computed; WB_ZERO_REG_EN switches the r0 expectations.
module tb_byte_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        res_valid;
    logic        res_ready;
    logic        res_we;
    logic [2:0]  res_rd;
    logic [7:0]  res_data;
    logic        wb_stall;
    logic [2:0]  rs1_addr;
    logic [7:0]  rs1_data;
    logic [2:0]  rs2_addr;
    logic [7:0]  rs2_data;
    logic        wb_pending;
    logic [15:0] retire_cnt;

    int unsigned n_checks;
    int unsigned n_fails;

    byte_wb_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_we     (res_we),
        .res_rd     (res_rd),
        .res_data   (res_data),
        .wb_stall   (wb_stall),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .wb_pending (wb_pending),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] rd, input logic [7:0] d);
        res_valid = v;
        res_we    = we;
        res_rd    = rd;
        res_data  = d;
    endtask

    logic [7:0] exp_r0;

    initial begin
        n_checks = 0;
        n_fails  = 0;
`ifdef WB_ZERO_REG_EN
        exp_r0 = 8'h00;
`else
        exp_r0 = 8'h11;
`endif
        rst_n    = 1'b0;
        wb_stall = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check_eq("init_ready", 32'(res_ready), 32'd1);
        check_eq("init_pending", 32'(wb_pending), 32'd0);
        check_eq("init_cnt", 32'(retire_cnt), 32'd0);

        // Reset while a stalled result is held
        drive(1'b1, 1'b1, 3'd5, 8'h77);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        drive(1'b1, 1'b1, 3'd6, 8'h66);
        wb_stall = 1'b1;
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        check_eq("stall_pending", 32'(wb_pending), 32'd1);
        check_eq("stall_ready", 32'(res_ready), 32'd0);
        check_eq("pre_rst_cnt", 32'(retire_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_pending", 32'(wb_pending), 32'd0);
        check_eq("rst_cnt", 32'(retire_cnt), 32'd0);
        for (int a = 0; a < 8; a++) begin
            rs1_addr = 3'(a);
            #1;
            check_eq($sformatf("rst_r%0d", a), 32'(rs1_data), 32'd0);
        end
        wb_stall = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_eq("rel_ready", 32'(res_ready), 32'd1);

        // Basic write with forwarding, then from storage
        drive(1'b1, 1'b1, 3'd3, 8'hA5);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        rs1_addr = 3'd3;
        #1;
        check_eq("fwd_r3", 32'(rs1_data), 32'hA5);
        check_eq("fwd_pending", 32'(wb_pending), 32'd1);
        step();
        check_eq("store_r3", 32'(rs1_data), 32'hA5);
        check_eq("basic_pending", 32'(wb_pending), 32'd0);
        check_eq("basic_cnt", 32'(retire_cnt), 32'd1);

        // Back-to-back r0..r7 = 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 3'(i), 8'((i + 1) * 8'h11));
            #1;
            check_eq($sformatf("b2b_ready%0d", i), 32'(res_ready), 32'd1);
            step();
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        check_eq("b2b_cnt", 32'(retire_cnt), 32'd9);
        check_eq("b2b_pending", 32'(wb_pending), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rs1_addr = 3'(i);
            rs2_addr = 3'(7 - i);
            #1;
            check_eq($sformatf("b2b_rs1_r%0d", i), 32'(rs1_data),
                     (i == 0) ? 32'(exp_r0) : 32'((i + 1) * 8'h11));
            check_eq($sformatf("b2b_rs2_r%0d", 7 - i), 32'(rs2_data),
                     (i == 7) ? 32'(exp_r0) : 32'((8 - i) * 8'h11));
        end
        step();

        // Stall for 3 cycles with a new result waiting
        drive(1'b1, 1'b1, 3'd4, 8'h44);
        step();
        drive(1'b1, 1'b1, 3'd5, 8'hAB);
        wb_stall = 1'b1;
        rs1_addr = 3'd4;
        rs2_addr = 3'd5;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("stl_ready%0d", k), 32'(res_ready), 32'd0);
            check_eq($sformatf("stl_cnt%0d", k), 32'(retire_cnt), 32'd9);
            check_eq($sformatf("stl_fwd_r4_%0d", k), 32'(rs1_data), 32'h44);
            check_eq($sformatf("stl_r5_%0d", k), 32'(rs2_data), 32'h66);
            step();
        end
        wb_stall = 1'b0;
        #1;
        check_eq("unstl_ready", 32'(res_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        check_eq("unstl_cnt", 32'(retire_cnt), 32'd10);
        check_eq("unstl_pending", 32'(wb_pending), 32'd1);
        check_eq("unstl_r4", 32'(rs1_data), 32'h44);
        check_eq("unstl_fwd_r5", 32'(rs2_data), 32'hAB);
        step();
        check_eq("unstl_cnt2", 32'(retire_cnt), 32'd11);
        check_eq("unstl_r5", 32'(rs2_data), 32'hAB);

        // Non-write result
        drive(1'b1, 1'b0, 3'd2, 8'hFF);
        rs1_addr = 3'd2;
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        check_eq("nw_nofwd_r2", 32'(rs1_data), 32'h33);
        check_eq("nw_pending", 32'(wb_pending), 32'd1);
        step();
        check_eq("nw_r2", 32'(rs1_data), 32'h33);
        check_eq("nw_cnt", 32'(retire_cnt), 32'd12);

        // Write to r0
        drive(1'b1, 1'b1, 3'd0, 8'h5A);
        rs2_addr = 3'd0;
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        #1;
`ifdef WB_ZERO_REG_EN
        check_eq("r0_fwd", 32'(rs2_data), 32'h00);
`else
        check_eq("r0_fwd", 32'(rs2_data), 32'h5A);
`endif
        step();
`ifdef WB_ZERO_REG_EN
        check_eq("r0_store", 32'(rs2_data), 32'h00);
`else
        check_eq("r0_store", 32'(rs2_data), 32'h5A);
`endif
        check_eq("r0_cnt", 32'(retire_cnt), 32'd13);

        // Counter wrap: 65522 more commits reach 0xFFFF, one more wraps
        drive(1'b1, 1'b0, 3'd1, 8'h00);
        repeat (65522) step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        check_eq("cnt_ffff", 32'(retire_cnt), 32'hFFFF);
        drive(1'b1, 1'b0, 3'd1, 8'h00);
        step();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        check_eq("cnt_wrap", 32'(retire_cnt), 32'h0000);
        check_eq("wrap_pending", 32'(wb_pending), 32'd0);
        rs1_addr = 3'd1;
        #1;
        check_eq("wrap_r1", 32'(rs1_data), 32'h22);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
